// File: rtl/task_io_bridge.sv
// Byte-stream to DUT-word bridge: packs task-manager bytes, strobes them into a DUT,
// captures its outputs and returns a sized 32-bit answer packet. Optional trailer beat: TASK_IO_BRIDGE_TRAILER_EN.
module task_io_bridge #(
  parameter int unsigned DATA_WIDTH_IN  = 8,
  parameter int unsigned DATA_WIDTH_OUT = 16,
  parameter int unsigned NUM_WORDS_IN   = 256,
  parameter int unsigned NUM_WORDS_OUT  = 256,
  parameter int unsigned DUT_LATENCY    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_tdata_valid,
  input  logic [7:0]                i_tdata,
  input  logic                      i_tdata_last,
  output logic                      o_tready,
  output logic                      o_dut_enb,
  output logic [DATA_WIDTH_IN-1:0]  o_dut_data,
  input  logic [DATA_WIDTH_OUT-1:0] i_dut_data,
  input  logic                      i_dut_valid,
  input  logic                      i_tmanager_ready,
  output logic                      o_tanswer_ready,
  output logic [31:0]               o_tanswer_data,
  output logic                      o_tanswer_data_last,
  output logic [11:0]               o_packet_size_in_bytes,
  output logic                      o_overflow
);

  localparam int unsigned BYTES_IN = DATA_WIDTH_IN / 8;
  localparam int unsigned IN_AW    = $clog2(NUM_WORDS_IN);
  localparam int unsigned OUT_AW   = $clog2(NUM_WORDS_OUT);
  localparam int unsigned BI_W     = (BYTES_IN > 1) ? $clog2(BYTES_IN) : 1;
  localparam int unsigned LAT_W    = $clog2(DUT_LATENCY + 2);
  localparam int unsigned BEAT_W   = OUT_AW + 2;
`ifdef TASK_IO_BRIDGE_TRAILER_EN
  localparam int unsigned TRAILER  = 1;
`else
  localparam int unsigned TRAILER  = 0;
`endif

  typedef enum logic [1:0] {COLLECT, FLUSH, SEND} state_t;

  state_t                   state;
  logic [DATA_WIDTH_IN-1:0] in_mem [NUM_WORDS_IN];
  logic [31:0]              out_mem [NUM_WORDS_OUT];
  logic [IN_AW-1:0]         in_wr, in_rd;
  logic [IN_AW:0]           in_cnt, in_cnt_nxt;
  logic [OUT_AW-1:0]        out_wr, out_rd;
  logic [OUT_AW:0]          out_cnt, out_cnt_nxt, out_count;
  logic [DATA_WIDTH_IN-1:0] pack_q, packed_word;
  logic [BI_W-1:0]          byte_idx;
  logic [LAT_W-1:0]         lat_cnt;
  logic [BEAT_W-1:0]        beat_idx, total_beats, entry_total;
  logic                     overflow;
  logic                     ans_valid, ans_last;
  logic [31:0]              ans_data, tail_word, cap_word, entry_head, next_data;
  logic [11:0]              size_q;
  logic                     in_full, in_empty, out_full, feed_active;
  logic                     byte_take, word_done, in_push, in_pop, out_push, out_pop;
`ifdef TASK_IO_BRIDGE_TRAILER_EN
  logic [11:0]              byte_cnt;
  assign tail_word = {overflow, 19'b0, byte_cnt};
`else
  assign tail_word = '0;
`endif

  assign in_full     = (in_cnt == (IN_AW+1)'(NUM_WORDS_IN));
  assign in_empty    = (in_cnt == '0);
  assign out_full    = (out_cnt == (OUT_AW+1)'(NUM_WORDS_OUT));
  assign feed_active = (state != SEND);

  // Byte request is a pure function of registered state, held low while in reset
  assign o_tready  = !i_rst && (state == COLLECT) && !in_full;
  assign byte_take = i_tdata_valid && o_tready;

  // Little-endian packing; pack_q is cleared after each push so partial words zero-pad
  assign packed_word = pack_q | (DATA_WIDTH_IN'(i_tdata) << {byte_idx, 3'b000});
  assign word_done   = byte_take && ((byte_idx == BI_W'(BYTES_IN - 1)) || i_tdata_last);
  assign in_push     = word_done;
  assign in_pop      = feed_active && !in_empty;

  assign cap_word = 32'(i_dut_data);
  assign out_push = feed_active && i_dut_valid && !out_full;
  assign out_pop  = (state == SEND) && i_tmanager_ready && (beat_idx < BEAT_W'(out_count));

  always_comb begin
    in_cnt_nxt = in_cnt;
    if (in_push && !in_pop)      in_cnt_nxt = in_cnt + (IN_AW+1)'(1);
    else if (!in_push && in_pop) in_cnt_nxt = in_cnt - (IN_AW+1)'(1);
    out_cnt_nxt = out_cnt;
    if (out_push && !out_pop)      out_cnt_nxt = out_cnt + (OUT_AW+1)'(1);
    else if (!out_push && out_pop) out_cnt_nxt = out_cnt - (OUT_AW+1)'(1);
  end

  // Answer sequencing: a capture landing in the sealing cycle still counts
  always_comb begin
    entry_total = BEAT_W'(out_cnt_nxt) + BEAT_W'(TRAILER);
    entry_head  = tail_word;
    if (out_cnt_nxt != '0) entry_head = (out_cnt == '0) ? cap_word : out_mem[out_rd];
    total_beats = BEAT_W'(out_count) + BEAT_W'(TRAILER);
    if (total_beats == '0) total_beats = BEAT_W'(1);
    next_data = tail_word;
    if ((beat_idx + BEAT_W'(1)) < BEAT_W'(out_count)) next_data = out_mem[out_rd + OUT_AW'(1)];
  end

  // Storage arrays, no reset needed
  always_ff @(posedge i_clk) begin
    if (in_push)  in_mem[in_wr]   <= packed_word;
    if (out_push) out_mem[out_wr] <= cap_word;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= COLLECT;
      in_wr      <= '0;
      in_rd      <= '0;
      in_cnt     <= '0;
      out_wr     <= '0;
      out_rd     <= '0;
      out_cnt    <= '0;
      out_count  <= '0;
      pack_q     <= '0;
      byte_idx   <= '0;
      lat_cnt    <= '0;
      beat_idx   <= '0;
      overflow   <= 1'b0;
      ans_valid  <= 1'b0;
      ans_last   <= 1'b0;
      ans_data   <= '0;
      size_q     <= '0;
      o_dut_enb  <= 1'b0;
      o_dut_data <= '0;
`ifdef TASK_IO_BRIDGE_TRAILER_EN
      byte_cnt   <= '0;
`endif
    end else begin
      if (in_push)  in_wr  <= in_wr + IN_AW'(1);
      if (in_pop)   in_rd  <= in_rd + IN_AW'(1);
      if (out_push) out_wr <= out_wr + OUT_AW'(1);
      if (out_pop)  out_rd <= out_rd + OUT_AW'(1);
      in_cnt  <= in_cnt_nxt;
      out_cnt <= out_cnt_nxt;

      if (byte_take) begin
        if (word_done) begin
          pack_q   <= '0;
          byte_idx <= '0;
        end else begin
          pack_q   <= packed_word;
          byte_idx <= byte_idx + BI_W'(1);
        end
`ifdef TASK_IO_BRIDGE_TRAILER_EN
        byte_cnt <= byte_cnt + 12'd1;
`endif
      end

      o_dut_enb <= in_pop;
      if (in_pop) o_dut_data <= in_mem[in_rd];

      if (feed_active && i_dut_valid && out_full) overflow <= 1'b1;

      case (state)
        COLLECT: begin
          if (byte_take && i_tdata_last) state <= FLUSH;
        end
        FLUSH: begin
          // Latency window restarts whenever a word is still going into the DUT
          if (o_dut_enb || !in_empty) begin
            lat_cnt <= '0;
          end else if (lat_cnt == LAT_W'(DUT_LATENCY)) begin
            state     <= SEND;
            lat_cnt   <= '0;
            out_count <= out_cnt_nxt;
            beat_idx  <= '0;
            ans_valid <= 1'b1;
            ans_data  <= entry_head;
            ans_last  <= (entry_total <= BEAT_W'(1));
            size_q    <= 12'({out_cnt_nxt, 2'b00}) + 12'(TRAILER * 4);
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        SEND: begin
          if (i_tmanager_ready) begin
            if (ans_last) begin
              state     <= COLLECT;
              ans_valid <= 1'b0;
              ans_last  <= 1'b0;
              ans_data  <= '0;
              size_q    <= '0;
              overflow  <= 1'b0;
              out_count <= '0;
              beat_idx  <= '0;
`ifdef TASK_IO_BRIDGE_TRAILER_EN
              byte_cnt  <= '0;
`endif
            end else begin
              beat_idx <= beat_idx + BEAT_W'(1);
              ans_data <= next_data;
              ans_last <= ((beat_idx + BEAT_W'(2)) == total_beats);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign o_tanswer_ready        = ans_valid;
  assign o_tanswer_data         = ans_data;
  assign o_tanswer_data_last    = ans_last;
  assign o_packet_size_in_bytes = size_q;
  assign o_overflow             = overflow;

endmodule

// File: tb/tb_task_io_bridge.sv
// Randomized bench for task_io_bridge (16-bit packing, 8-deep answer FIFO) with a
// behavioural DUT that returns word+1 two cycles after each enable.
module tb_task_io_bridge;

  localparam int unsigned DIN  = 16;
  localparam int unsigned DOUT = 16;
  localparam int unsigned NIN  = 16;
  localparam int unsigned NOUT = 8;
  localparam int unsigned LAT  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tdata_valid = 1'b0;
  logic [7:0]      tdata = '0;
  logic            tdata_last = 1'b0;
  logic            tready;
  logic            dut_enb;
  logic [DIN-1:0]  dut_data;
  logic [DOUT-1:0] dut_out;
  logic            dut_valid;
  logic            mgr_ready = 1'b0;
  logic            ans_ready;
  logic [31:0]     ans_data;
  logic            ans_last;
  logic [11:0]     pkt_size;
  logic            overflow;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned    pkt_q[$];
  bit              emit_q[$];
  logic [DIN-1:0]  seen_q[$];

  always #5 clk = ~clk;

  task_io_bridge #(
    .DATA_WIDTH_IN(DIN), .DATA_WIDTH_OUT(DOUT), .NUM_WORDS_IN(NIN),
    .NUM_WORDS_OUT(NOUT), .DUT_LATENCY(LAT)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_tdata_valid(tdata_valid), .i_tdata(tdata), .i_tdata_last(tdata_last),
    .o_tready(tready), .o_dut_enb(dut_enb), .o_dut_data(dut_data),
    .i_dut_data(dut_out), .i_dut_valid(dut_valid),
    .i_tmanager_ready(mgr_ready), .o_tanswer_ready(ans_ready),
    .o_tanswer_data(ans_data), .o_tanswer_data_last(ans_last),
    .o_packet_size_in_bytes(pkt_size), .o_overflow(overflow)
  );

  // Behavioural DUT: two-stage pipeline, per-word emit decision from emit_q
  logic            s1_v, s2_v;
  logic [DOUT-1:0] s1_d, s2_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0;
    end else begin
      s1_v <= 1'b0;
      if (dut_enb) begin
        seen_q.push_back(dut_data);
        s1_v <= (emit_q.size() > 0) ? emit_q.pop_front() : 1'b0;
        s1_d <= dut_data + 16'd1;
      end
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end
  assign dut_valid = s2_v;
  assign dut_out   = s2_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offers the first n_send bytes of pkt_q with random idle gaps; entry/exit at posedge+1
  task automatic send_bytes(input int n_send);
    for (int i = 0; i < n_send; i++) begin
      bit took = 1'b0;
      int guard = 0;
      if ($urandom_range(3) == 0) begin
        tdata_valid = 1'b0;
        @(posedge clk); #1;
      end
      tdata_valid = 1'b1;
      tdata       = pkt_q[i];
      tdata_last  = (i == pkt_q.size() - 1);
      while (!took && guard < 200) begin
        @(negedge clk);
        took = tready;
        @(posedge clk); #1;
        guard++;
      end
      if (!took) check("tready_timeout", 32'(took), 32'd1);
    end
    tdata_valid = 1'b0;
    tdata_last  = 1'b0;
  endtask

  // Full packet: build reference answer from the bytes, send, collect and compare
  task automatic run_packet(input string name, input int emit_pct, input int rdy_mode);
    logic [15:0] words[$];
    logic [31:0] outs[$];
    logic [31:0] exp_ans[$];
    logic [31:0] got[$];
    bit          got_last[$];
    int          nb = pkt_q.size();
    int          n_ret, cyc, stab_err, size_err;
    bit          exp_ovf, done, prev_stall, seen_ovf;
    logic [31:0] prev_data;
    logic [11:0] exp_size;

    for (int i = 0; i < nb; i += 2) begin
      int w = pkt_q[i];
      if (i + 1 < nb) w += 256 * pkt_q[i+1];
      words.push_back(16'(w));
    end
    emit_q.delete();
    seen_q.delete();
    foreach (words[i]) begin
      bit e = ($urandom_range(99) < emit_pct);
      emit_q.push_back(e);
      if (e) outs.push_back(32'((int'(words[i]) + 1) % 65536));
    end
    exp_ovf = (outs.size() > NOUT);
    n_ret   = exp_ovf ? NOUT : outs.size();
    for (int i = 0; i < n_ret; i++) exp_ans.push_back(outs[i]);
    exp_size = 12'(n_ret * 4);
`ifdef TASK_IO_BRIDGE_TRAILER_EN
    exp_ans.push_back({exp_ovf, 19'b0, 12'(nb)});
    exp_size = exp_size + 12'd4;
`else
    if (n_ret == 0) exp_ans.push_back(32'd0);
`endif

    send_bytes(nb);
    check({name, ":tready_after_last"}, 32'(tready), 32'd0);

    cyc = 0; stab_err = 0; size_err = 0; done = 1'b0; prev_stall = 1'b0; seen_ovf = 1'b0;
    prev_data = '0;
    while (!done && cyc < 3000) begin
      mgr_ready = (rdy_mode == 1) ? (cyc % 3 == 0) : ($urandom_range(1) == 1);
      @(negedge clk);
      if (ans_ready) begin
        seen_ovf = overflow;
        if (prev_stall && ans_data !== prev_data) stab_err++;
        if (pkt_size !== exp_size) size_err++;
        if (mgr_ready) begin
          got.push_back(ans_data);
          got_last.push_back(ans_last);
          prev_stall = 1'b0;
          if (ans_last) done = 1'b1;
        end else begin
          prev_stall = 1'b1;
          prev_data  = ans_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    mgr_ready = 1'b0;

    check({name, ":answer_done"}, 32'(done), 32'd1);
    check({name, ":enables"}, 32'(seen_q.size()), 32'(words.size()));
    for (int i = 0; i < words.size() && i < seen_q.size(); i++)
      check({name, ":dut_word"}, 32'(seen_q[i]), 32'(words[i]));
    check({name, ":beats"}, 32'(got.size()), 32'(exp_ans.size()));
    for (int i = 0; i < got.size() && i < exp_ans.size(); i++) begin
      check({name, ":beat_data"}, got[i], exp_ans[i]);
      check({name, ":beat_last"}, 32'(got_last[i]), 32'(i == exp_ans.size() - 1));
    end
    check({name, ":size_const"}, 32'(size_err), 32'd0);
    check({name, ":stable_on_stall"}, 32'(stab_err), 32'd0);
    check({name, ":overflow"}, 32'(seen_ovf), 32'(exp_ovf));
    check({name, ":tready_after_send"}, 32'(tready), 32'd1);
    check({name, ":size_idle"}, 32'(pkt_size), 32'd0);
    check({name, ":overflow_cleared"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst:tready", 32'(tready), 32'd0);
    check("rst:answer_ready", 32'(ans_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst:tready_release", 32'(tready), 32'd1);
    check("rst:dut_enb", 32'(dut_enb), 32'd0);
    check("rst:size", 32'(pkt_size), 32'd0);
    @(posedge clk); #1;

    // Directed odd-length packing: 0xBBAA then zero-padded 0x00CC
    pkt_q = '{8'hAA, 8'hBB, 8'hCC};
    run_packet("pack3", 100, 0);

    // Overflow: 12 outputs into an 8-deep answer FIFO
    pkt_q.delete();
    for (int i = 0; i < 24; i++) pkt_q.push_back(8'($urandom));
    run_packet("overflow", 100, 0);

    // Manager ready pattern 1,0,0,1,...
    pkt_q.delete();
    for (int i = 0; i < 10; i++) pkt_q.push_back(8'($urandom));
    run_packet("rdy_pattern", 100, 1);

    // DUT never valid
    pkt_q.delete();
    for (int i = 0; i < 200; i++) pkt_q.push_back(8'($urandom));
    run_packet("no_output", 0, 0);

    // Reset half-way through a 200-byte packet
    pkt_q.delete();
    for (int i = 0; i < 200; i++) pkt_q.push_back(8'($urandom));
    emit_q.delete();
    for (int i = 0; i < 100; i++) emit_q.push_back(1'b1);
    send_bytes(100);
    rst = 1'b1;
    #1;
    check("midrst:dut_enb", 32'(dut_enb), 32'd0);
    check("midrst:dut_data", 32'(dut_data), 32'd0);
    check("midrst:tready", 32'(tready), 32'd0);
    check("midrst:answer_ready", 32'(ans_ready), 32'd0);
    check("midrst:answer_data", ans_data, 32'd0);
    check("midrst:answer_last", 32'(ans_last), 32'd0);
    check("midrst:size", 32'(pkt_size), 32'd0);
    check("midrst:overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst:tready_release", 32'(tready), 32'd1);
    @(posedge clk); #1;
    pkt_q.delete();
    for (int i = 0; i < 9; i++) pkt_q.push_back(8'($urandom));
    run_packet("after_rst", 100, 0);

    // Random packets
    for (int p = 0; p < 8; p++) begin
      int len = $urandom_range(40, 1);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
      run_packet($sformatf("rand%0d", p), $urandom_range(100), $urandom_range(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/task_io_bridge.md
Name: task_io_bridge

Overview:
- Parametrised successor to the per-task in/out buffer pair.
- Accepts the byte stream from the task manager and packs it into DATA_WIDTH_IN words.
- Feeds the packed words to a DUT with an enable strobe, collects the DUT's detected outputs, and returns them to the task manager as a sized 32-bit answer packet.
- Sits between the task interfaces and any DUT. Flat ports; the task wrapper connects the interfaces.

Parameters:
- DATA_WIDTH_IN, 8: DUT input width. Multiple of 8, range 8..32; BYTES_IN = DATA_WIDTH_IN/8.
- DATA_WIDTH_OUT, 16: DUT output width, 1..32; zero-extended to 32 on the answer bus.
- NUM_WORDS_IN, 256: input FIFO depth in packed words, power of two.
- NUM_WORDS_OUT, 256: output FIFO depth in words, power of two; NUM_WORDS_OUT*4+4 must be < 4096.
- DUT_LATENCY, 4: cycles waited after the last enable before the answer is sealed.

Ports:
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_tdata_valid  in  1  input byte valid
- i_tdata  in  8  input byte
- i_tdata_last  in  1  marks the last byte of the task packet
- o_tready  out  1  byte request; a byte is taken when valid && o_tready
- o_dut_enb  out  1  one-cycle strobe per word presented to the DUT
- o_dut_data  out  DATA_WIDTH_IN  DUT input word
- i_dut_data  in  DATA_WIDTH_OUT  DUT output word
- i_dut_valid  in  1  DUT output valid (detected)
- i_tmanager_ready  in  1  manager accepts the current answer beat
- o_tanswer_ready  out  1  answer beat valid
- o_tanswer_data  out  32  answer word
- o_tanswer_data_last  out  1  final answer beat
- o_packet_size_in_bytes  out  12  answer size, valid while o_tanswer_ready
- o_overflow  out  1  sticky output-FIFO overflow flag

Behaviour:
- Reset, asynchronous, applied at any point including mid-packet:
  - FSM goes to COLLECT; both FIFOs, the packer and all counters clear.
  - All outputs go to 0, except o_tready = 1 as soon as reset deasserts.
- FSM states: COLLECT -> FLUSH -> SEND -> COLLECT.
- COLLECT, packing:
  - o_tready = !in_fifo_full. A byte offered while o_tready = 0 is not consumed.
  - Bytes pack little-endian: the first byte goes to bits [7:0].
  - A word is pushed when BYTES_IN bytes have been accepted, or on the last byte with a partial word; upper bytes of a partial word are zero-padded.
  - Accepting the last byte moves the FSM to FLUSH and drops o_tready to 0 on the next cycle.
- DUT feed, active in COLLECT and FLUSH:
  - When the input FIFO is non-empty, pop one word per cycle.
  - o_dut_data is registered, with o_dut_enb = 1 in the same cycle.
  - Otherwise o_dut_enb = 0 and o_dut_data holds its value.
- Capture, active in COLLECT and FLUSH:
  - Each cycle with i_dut_valid = 1 pushes {zero-extend, i_dut_data} into the output FIFO.
  - If the output FIFO is full, the word is dropped and o_overflow is set; o_overflow clears only on reset or on entry to COLLECT from SEND.
  - i_dut_valid in SEND is ignored.
- FLUSH:
  - Once the input FIFO is empty, count DUT_LATENCY cycles; the counter restarts on any o_dut_enb.
  - Then latch out_count = words in the output FIFO, size = out_count*4 (plus trailer, see the optional feature), and enter SEND.
- SEND:
  - o_tanswer_ready = 1 and o_tanswer_data = FIFO head, shown first-word-fall-through.
  - A beat retires when i_tmanager_ready = 1 and the next word appears the following cycle.
  - o_tanswer_data_last = 1 on the final beat only.
  - After the final beat is accepted, return to COLLECT with o_tready = 1 the next cycle.
  - o_tanswer_ready may stay high across cycles where the manager is not ready; data is held stable.
- Zero outputs: SEND emits a single beat with data 0, last = 1 and size 0.
- o_packet_size_in_bytes is constant for the whole of SEND and 0 outside SEND.
- A new packet's bytes are not requested until SEND completes; there is no overlap.

Optional Feature:
- Macro: TASK_IO_BRIDGE_TRAILER_EN.
- When defined:
  - One extra trailer beat is appended after the data words: {o_overflow, 19'b0, input byte count[11:0]}.
  - Size = out_count*4 + 4; the trailer carries last = 1.
  - The zero-output case sends only the trailer, with size 4.
- When undefined: no trailer beat; sizes are exactly as in Behaviour.

Test Plan:
- Default parameters, 3 bytes 0x11,0x22,0x33 (last on 0x33), DUT model echoing pre+1 after 2 cycles -> answer 0x12,0x23,0x34, size 12, last on the third beat.
- DATA_WIDTH_IN=16, 3 bytes 0xAA,0xBB,0xCC -> o_dut_data 0xBBAA then 0x00CC; exactly 2 enable strobes.
- NUM_WORDS_OUT=4 with 6 DUT outputs -> 4 words returned, size 16, o_overflow = 1.
- Manager ready toggling 1,0,0,1,... during SEND -> no beat lost or duplicated; data stable while ready = 0.
- Reset asserted after 100 of 200 bytes -> all outputs 0 immediately; next clean packet answered correctly with o_overflow = 0.
- DUT never valid -> single beat data 0, last = 1, size 0; with TRAILER_EN: trailer byte count 200, size 4.
